// File: rtl/fpmul_rr_scheduler_pkg.sv
// Shared types and default sizes for the FP multiplier round-robin scheduler.
// Contents: operand width, default latency/requester count, requester id and
// tag-pipe entry types.
package fpmul_sched_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned MUL_LAT_DEF = 4;
  localparam int unsigned N_REQ_DEF   = 4;
  // Ids are sized for the largest supported requester count so one tag type
  // serves every legal N_REQ.
  localparam int unsigned N_REQ_MAX   = 8;
  localparam int unsigned ID_W        = $clog2(N_REQ_MAX);

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic vld;
    id_t  id;
  } tag_t;

endpackage

// File: rtl/fpmul_rr_scheduler_if.sv
// Client and multiplier-side bundle for fpmul_rr_scheduler.
// master: client/multiplier side (drives requests, resp_ready, mul_z).
// slave : scheduler side (drives grants, responses, mul operands, in_flight).
interface fpmul_rr_scheduler_if
  import fpmul_sched_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF
);
  localparam int unsigned CNT_W = $clog2(N_REQ + 1);

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0][DATA_W-1:0] req_a;
  logic [N_REQ-1:0][DATA_W-1:0] req_b;
  logic [N_REQ-1:0]             resp_valid;
  logic [N_REQ-1:0]             resp_ready;
  logic [N_REQ-1:0][DATA_W-1:0] resp_data;
  logic [DATA_W-1:0]            mul_a;
  logic [DATA_W-1:0]            mul_b;
  logic [DATA_W-1:0]            mul_z;
  logic [CNT_W-1:0]             in_flight;

  modport master (
    output req_valid, req_a, req_b, resp_ready, mul_z,
    input  req_ready, resp_valid, resp_data, mul_a, mul_b, in_flight
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mul_z,
    output req_ready, resp_valid, resp_data, mul_a, mul_b, in_flight
  );

endinterface

// File: rtl/fpmul_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (request vector), ptr (highest-priority index this cycle),
//        gnt (one-hot grant, zero when no request), gnt_idx (granted index).
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] idx;
  logic          found;

  // Scan from ptr upward with wrap; the first requester seen wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/fpmul_rr_scheduler.sv
// Shares one fixed-latency, non-stallable FP multiplier between N_REQ
// requesters. Round-robin issue of at most one op per cycle, a tag pipe
// matched to the multiplier latency, and a one-deep result slot per requester.
// Ports: clk, rst (sync, active-high), bus (slave side: per-requester
//        request/response handshakes, mul_a/mul_b/mul_z, in_flight).
module fpmul_rr_scheduler
  import fpmul_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input logic                 clk,
  input logic                 rst,
  fpmul_rr_scheduler_if.slave bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(N_REQ + 1);
  localparam int unsigned N_STG = MUL_LAT + 1;

  logic [N_REQ-1:0]             pend_q;
  logic [N_REQ-1:0]             busy_c;
  logic [N_REQ-1:0]             elig_c;
  logic [N_REQ-1:0]             gnt_c;
  logic [PTR_W-1:0]             gnt_idx_c;
  logic                         gnt_any_c;
  logic [PTR_W-1:0]             ptr_q;
  tag_t                         tag_q [N_STG];
  logic [N_REQ-1:0]             ret_c;
  logic                         ret_any_c;
  logic [N_REQ-1:0]             resp_valid_q;
  logic [N_REQ-1:0][DATA_W-1:0] resp_data_q;
  logic [DATA_W-1:0]            mul_a_q;
  logic [DATA_W-1:0]            mul_b_q;
  logic [CNT_W-1:0]             in_flight_q;

  // A requester stays ineligible until its product has been consumed, so
  // each result slot can never be overwritten.
  assign busy_c = pend_q | resp_valid_q;
  assign elig_c = bus.req_valid & ~busy_c & {N_REQ{~rst}};

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (elig_c),
    .ptr     (ptr_q),
    .gnt     (gnt_c),
    .gnt_idx (gnt_idx_c)
  );

  assign gnt_any_c     = |gnt_c;
  assign bus.req_ready = gnt_c;

  // Tag leaving the last stage lines up with mul_z for the op it describes.
  assign ret_any_c = tag_q[N_STG-1].vld;
  always_comb begin
    ret_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ret_c[i] = tag_q[N_STG-1].vld && (tag_q[N_STG-1].id == id_t'(i));
    end
  end

  // Tag pipe: free-running shift, one entry per multiplier stage plus the
  // operand register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_STG; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0].vld <= gnt_any_c;
      tag_q[0].id  <= id_t'(gnt_idx_c);
      for (int s = 1; s < N_STG; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // Issue side: operand capture, pointer advance, pending flags, op count.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      ptr_q       <= '0;
      pend_q      <= '0;
      in_flight_q <= '0;
    end else begin
      if (gnt_any_c) begin
        mul_a_q <= bus.req_a[gnt_idx_c];
        mul_b_q <= bus.req_b[gnt_idx_c];
        ptr_q   <= (gnt_idx_c == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx_c + PTR_W'(1);
      end
      pend_q <= (pend_q | gnt_c) & ~ret_c;
      case ({gnt_any_c, ret_any_c})
        2'b10:   in_flight_q <= in_flight_q + CNT_W'(1);
        2'b01:   in_flight_q <= in_flight_q - CNT_W'(1);
        default: in_flight_q <= in_flight_q;
      endcase
    end
  end

  // Result slots: load on return, hold until the requester takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (ret_c[i]) begin
          resp_valid_q[i] <= 1'b1;
          resp_data_q[i]  <= bus.mul_z;
        end else if (resp_valid_q[i] && bus.resp_ready[i]) begin
          resp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.in_flight  = in_flight_q;

endmodule

// File: tb/tb_fpmul_rr_scheduler.sv
// Self-checking bench for fpmul_rr_scheduler with a behavioural fixed-latency
// multiplier and a scoreboard of expected products and return cycles.
module tb_fpmul_rr_scheduler;
  import fpmul_sched_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned LAT  = 4;
  localparam int          RLAT = int'(LAT) + 2;

  typedef struct {
    int                id;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fpmul_rr_scheduler_if #(.N_REQ(N)) bus ();
  fpmul_rr_scheduler #(.N_REQ(N), .MUL_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: exact products for the named operands, a fixed mix otherwise.
  function automatic logic [DATA_W-1:0] mul_model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    case ({a, b})
      {32'h3FC00000, 32'h40000000}: return 32'h40400000;
      {32'hC0000000, 32'h3F000000}: return 32'hBF800000;
      {32'h40200000, 32'h40800000}: return 32'h41200000;
      {32'h00000000, 32'h40E00000}: return 32'h00000000;
      default:                      return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000;
    endcase
  endfunction

  logic [DATA_W-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_model(bus.mul_a, bus.mul_b);
    for (int unsigned s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
  end
  assign bus.mul_z = mpipe[LAT-1];

  int errors = 0;
  int checks = 0;
  int cnt    = 0;
  exp_t sbq[$];
  logic [N-1:0] seen = '0;

  logic [N-1:0]             s_hs, s_ready, s_rv;
  logic [N-1:0][DATA_W-1:0] s_rdata;
  logic [DATA_W-1:0]        s_mul_a, s_mul_b;
  logic [2:0]               s_inf;

  function automatic int find(input int id);
    for (int j = 0; j < sbq.size(); j++) if (sbq[j].id == id) return j;
    return -1;
  endfunction

  // One clock: snapshot outputs mid-cycle, run the scoreboard, resume after the edge.
  task automatic cycle();
    int k;
    @(negedge clk);
    s_hs    = bus.req_valid & bus.req_ready;
    s_ready = bus.req_ready;
    s_rv    = bus.resp_valid;
    s_rdata = bus.resp_data;
    s_mul_a = bus.mul_a;
    s_mul_b = bus.mul_b;
    s_inf   = bus.in_flight;
    if (rst) begin
      sbq.delete();
      seen = '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (s_hs[i]) sbq.push_back('{i, mul_model(bus.req_a[i], bus.req_b[i]), cnt + RLAT});
        if (s_rv[i] && !seen[i]) begin
          seen[i] = 1'b1;
          k = find(i);
          checks++;
          if (k < 0) begin
            errors++;
            $display("FAIL sb_unexpected_resp req%0d cycle %0d data %h", i, cnt, s_rdata[i]);
          end else if (sbq[k].due != cnt) begin
            errors++;
            $display("FAIL sb_resp_cycle req%0d got cycle %0d exp %0d", i, cnt, sbq[k].due);
          end
        end
        if (s_rv[i] && bus.resp_ready[i]) begin
          seen[i] = 1'b0;
          k = find(i);
          if (k >= 0) begin
            checks++;
            if (s_rdata[i] !== sbq[k].data) begin
              errors++;
              $display("FAIL sb_resp_data req%0d got %h exp %h", i, s_rdata[i], sbq[k].data);
            end
            sbq.delete(k);
          end
        end
      end
    end
    cnt++;
    @(posedge clk);
    #1;
  endtask

  // Accepted requesters either drop valid or present fresh operands.
  task automatic step(input logic [N-1:0] renew);
    cycle();
    for (int i = 0; i < int'(N); i++) begin
      if (s_hs[i]) begin
        if (renew[i]) begin
          bus.req_a[i] = $urandom;
          bus.req_b[i] = $urandom;
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    step('0);
    step('0);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sbq.size() != 0 || bus.resp_valid != '0) && n < budget) begin
      step('0);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout outstanding %0d exp 0", sbq.size());
    end
  endtask

  task automatic load4();
    bus.req_a[0] = 32'h3FC00000; bus.req_b[0] = 32'h40000000;
    bus.req_a[1] = 32'hC0000000; bus.req_b[1] = 32'h3F000000;
    bus.req_a[2] = 32'h40200000; bus.req_b[2] = 32'h40800000;
    bus.req_a[3] = 32'h00000000; bus.req_b[3] = 32'h40E00000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    load4();
    step('0);
    checks++; if (s_ready !== '0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", s_ready); end
    checks++; if (s_rv !== '0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", s_rv); end
    checks++; if (s_mul_a !== '0) begin errors++; $display("FAIL rst_mul_a got %h exp 0", s_mul_a); end
    checks++; if (s_mul_b !== '0) begin errors++; $display("FAIL rst_mul_b got %h exp 0", s_mul_b); end
    checks++; if (s_inf !== '0) begin errors++; $display("FAIL rst_in_flight got %0d exp 0", s_inf); end
    bus.req_valid = '0;
    step('0);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic bad = 1'b0;
    bus.req_a[0] = 32'h3FC00000;
    bus.req_b[0] = 32'h40000000;
    bus.req_valid = 4'b0001;
    step('0);
    checks++; if (s_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", s_ready); end
    step('0);
    checks++; if (s_mul_a !== 32'h3FC00000) begin errors++; $display("FAIL single_mul_a got %h exp 3fc00000", s_mul_a); end
    checks++; if (s_mul_b !== 32'h40000000) begin errors++; $display("FAIL single_mul_b got %h exp 40000000", s_mul_b); end
    for (int r = 2; r < 6; r++) begin
      step('0);
      if (s_rv[0]) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL single_early_resp got 1 exp 0"); end
    step('0);
    checks++; if (s_rv[0] !== 1'b1) begin errors++; $display("FAIL single_resp_valid got %b exp 1", s_rv[0]); end
    checks++; if (s_rdata[0] !== 32'h40400000) begin errors++; $display("FAIL single_resp_data got %h exp 40400000", s_rdata[0]); end
    wait_drain(20);
  endtask

  task automatic test_all_four();
    logic [DATA_W-1:0] e4 [4];
    logic [2:0] peak = '0;
    e4[0] = 32'h40400000; e4[1] = 32'hBF800000; e4[2] = 32'h41200000; e4[3] = 32'h00000000;
    do_reset();
    load4();
    bus.req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      step('0);
      if (s_inf > peak) peak = s_inf;
      checks++;
      if (s_ready !== N'(1 << k)) begin errors++; $display("FAIL all4_grant cycle %0d got %b exp %b", k, s_ready, N'(1 << k)); end
    end
    for (int r = 4; r < 12; r++) begin
      step('0);
      if (s_inf > peak) peak = s_inf;
      if (r >= 6 && r <= 9) begin
        checks++;
        if (s_rv !== N'(1 << (r - 6)) || s_rdata[r-6] !== e4[r-6]) begin
          errors++;
          $display("FAIL all4_resp cycle %0d got %b/%h exp %b/%h", r, s_rv, s_rdata[r-6], N'(1 << (r - 6)), e4[r-6]);
        end
      end
    end
    checks++; if (peak !== 3'd4) begin errors++; $display("FAIL all4_peak_in_flight got %0d exp 4", peak); end
    wait_drain(20);
  endtask

  task automatic test_reset_mid();
    logic bad = 1'b0;
    do_reset();
    load4();
    bus.req_valid = '1;
    for (int k = 0; k < 3; k++) step('0);
    rst = 1'b1;
    step('0);
    checks++; if (s_ready !== '0) begin errors++; $display("FAIL midrst_grant got %b exp 0", s_ready); end
    rst = 1'b0;
    bus.req_valid = 4'b1000;
    bus.req_a[3] = 32'h40200000;
    bus.req_b[3] = 32'h40800000;
    for (int r = 0; r < 10; r++) begin
      step('0);
      if (r == 0) begin
        checks++; if (s_ready !== 4'b1000) begin errors++; $display("FAIL midrst_regrant got %b exp 1000", s_ready); end
        checks++; if (s_inf !== 3'd0) begin errors++; $display("FAIL midrst_in_flight got %0d exp 0", s_inf); end
      end
      if (r == 1) begin
        checks++; if (s_inf !== 3'd1) begin errors++; $display("FAIL midrst_in_flight1 got %0d exp 1", s_inf); end
      end
      if (r == 6) begin
        checks++;
        if (s_rv !== 4'b1000 || s_rdata[3] !== 32'h41200000) begin
          errors++; $display("FAIL midrst_resp got %b/%h exp 1000/41200000", s_rv, s_rdata[3]);
        end
      end else if (s_rv !== '0) begin
        bad = 1'b1;
      end
    end
    checks++; if (bad) begin errors++; $display("FAIL midrst_stale_resp got 1 exp 0"); end
    wait_drain(20);
    step('0);
    checks++; if (s_inf !== 3'd0) begin errors++; $display("FAIL midrst_final_in_flight got %0d exp 0", s_inf); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] d1;
    logic bad = 1'b0;
    int others = 0;
    int n = 0;
    do_reset();
    bus.resp_ready = 4'b1101;
    for (int i = 0; i < 3; i++) begin bus.req_a[i] = $urandom; bus.req_b[i] = $urandom; end
    bus.req_valid = 4'b0111;
    do begin
      step(4'b0111);
      n++;
    end while (!s_rv[1] && n < 30);
    checks++; if (!s_rv[1]) begin errors++; $display("FAIL bp_resp_timeout got 0 exp 1"); end
    d1 = s_rdata[1];
    for (int h = 0; h < 10; h++) begin
      if (h == 9) begin bus.req_valid[0] = 1'b0; bus.req_valid[2] = 1'b0; end
      step(4'b0111);
      if (s_rdata[1] !== d1 || !s_rv[1] || s_ready[1]) bad = 1'b1;
      others += int'(s_hs[0]) + int'(s_hs[2]);
    end
    checks++; if (bad) begin errors++; $display("FAIL bp_hold got 1 exp 0"); end
    checks++; if (others < 2) begin errors++; $display("FAIL bp_others_issue got %0d exp >=2", others); end
    bus.resp_ready = '1;
    step(4'b0010);
    checks++; if (s_ready[1] !== 1'b0 || s_rv[1] !== 1'b1) begin errors++; $display("FAIL bp_hs_cycle got %b/%b exp 0/1", s_ready[1], s_rv[1]); end
    step(4'b0010);
    checks++; if (s_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_regrant got %b exp 1", s_ready[1]); end
    bus.req_valid = '0;
    wait_drain(30);
  endtask

  task automatic test_fairness();
    int g [6];
    int ng = 0;
    int n = 0;
    do_reset();
    bus.resp_ready = '1;
    bus.req_a[1] = $urandom; bus.req_b[1] = $urandom;
    bus.req_valid = 4'b0010;
    step('0);
    checks++; if (s_ready !== 4'b0010) begin errors++; $display("FAIL rr_setup got %b exp 0010", s_ready); end
    wait_drain(20);
    bus.req_a[0] = $urandom; bus.req_a[3] = $urandom;
    bus.req_valid = 4'b1001;
    step('0);
    checks++; if (s_ready !== 4'b1000) begin errors++; $display("FAIL rr_ptr got %b exp 1000", s_ready); end
    step('0);
    checks++; if (s_ready !== 4'b0001) begin errors++; $display("FAIL rr_next got %b exp 0001", s_ready); end
    wait_drain(20);
    do_reset();
    bus.req_valid = 4'b0101;
    while (ng < 6 && n < 80) begin
      step(4'b0101);
      if (s_hs != '0) begin
        g[ng] = (s_hs == 4'b0001) ? 0 : (s_hs == 4'b0100) ? 2 : 99;
        ng++;
      end
      n++;
    end
    checks++; if (ng != 6) begin errors++; $display("FAIL fair_grant_count got %0d exp 6", ng); end
    for (int j = 0; j < ng; j++) begin
      checks++;
      if (g[j] != ((j % 2 == 0) ? 0 : 2)) begin errors++; $display("FAIL fair_order[%0d] got %0d exp %0d", j, g[j], (j % 2 == 0) ? 0 : 2); end
    end
    bus.req_valid = '0;
    wait_drain(20);
  endtask

  task automatic test_throughput();
    int gc [4];
    int ng = 0;
    int n = 0;
    logic bad_hold = 1'b0;
    logic bad_op = 1'b0;
    logic prev_g = 1'b0;
    logic [DATA_W-1:0] prev_a = '0, prev_b = '0, cur_a, grant_a = '0;
    do_reset();
    bus.resp_ready = '1;
    bus.req_a[1] = $urandom; bus.req_b[1] = $urandom;
    bus.req_valid = 4'b0010;
    while (ng < 4 && n < 60) begin
      cur_a = bus.req_a[1];
      step(4'b0010);
      if (n > 0 && !prev_g && (s_mul_a !== prev_a || s_mul_b !== prev_b)) bad_hold = 1'b1;
      if (prev_g && s_mul_a !== grant_a) bad_op = 1'b1;
      prev_g = s_hs[1];
      if (s_hs[1]) begin
        gc[ng] = cnt;
        grant_a = cur_a;
        ng++;
      end
      prev_a = s_mul_a;
      prev_b = s_mul_b;
      n++;
    end
    checks++; if (ng != 4) begin errors++; $display("FAIL tput_grant_count got %0d exp 4", ng); end
    for (int j = 1; j < ng; j++) begin
      checks++;
      if (gc[j] - gc[j-1] != 7) begin errors++; $display("FAIL tput_gap[%0d] got %0d exp 7", j, gc[j] - gc[j-1]); end
    end
    checks++; if (bad_hold) begin errors++; $display("FAIL tput_mul_hold got 1 exp 0"); end
    checks++; if (bad_op) begin errors++; $display("FAIL tput_mul_operand got 1 exp 0"); end
    bus.req_valid = '0;
    wait_drain(20);
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = '1;
    test_reset();
    test_single();
    test_all_four();
    test_reset_mid();
    test_backpressure();
    test_fairness();
    test_throughput();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpmul_rr_scheduler.md
Name: fpmul_rr_scheduler

Overview:
- Shares one pipelined, non-stallable FP multiplier (FPmul: 32-bit operands, fixed latency) between N_REQ requesters.
- Per-requester valid/ready request and response channels; round-robin arbitration picks at most one issue per cycle.
- Tracks requester IDs through a tag shift register aligned to the multiplier latency, and routes each product back to the requester that issued it.
- Sits between the FP multiplier and the client blocks; replaces per-client fixed-wait FSM sequencing of the multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MUL_LAT, 4, cycles from operands stable on mul_a/mul_b to product valid on mul_z.
- DATA_W, 32, operand/result width (IEEE-754 single).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  request valid per requester.
- req_ready  out  N_REQ  request accepted (grant) per requester.
- req_a  in  N_REQ x DATA_W  operand A per requester.
- req_b  in  N_REQ x DATA_W  operand B per requester.
- resp_valid  out  N_REQ  product available per requester.
- resp_ready  in  N_REQ  requester consumes product.
- resp_data  out  N_REQ x DATA_W  product per requester.
- mul_a  out  DATA_W  operand A to FPmul (registered).
- mul_b  out  DATA_W  operand B to FPmul (registered).
- mul_z  in  DATA_W  product from FPmul.
- in_flight  out  $clog2(N_REQ+1)  count of issued, not yet returned operations.

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. At most one outstanding operation per requester.
- busy[i] = pend[i] | resp_valid[i], where pend[i] means issued and not yet returned. Both come from registers.
- Eligibility: elig[i] = req_valid[i] & ~busy[i].
- Grant: combinational round-robin over elig, starting at pointer ptr. Exactly one req_ready bit is high when any elig bit is set, otherwise none. req_ready[i] may depend on req_valid[i]; the handshake is req_valid & req_ready.
- Issue for grant to i in cycle t:
  - End of t: mul_a/mul_b <= req_a[i]/req_b[i]; tag stage0 <= {1, i}; pend[i] <= 1; ptr <= (i+1) mod N_REQ.
  - With no grant, ptr holds, tag stage0 valid <= 0, and mul_a/mul_b hold their old values.
- Tag pipe: MUL_LAT+1 stages of {vld, id}, shifting every cycle and never stalling.
- Return: when the last stage is valid (cycle t+1+MUL_LAT):
  - End of that cycle: resp_data[id] <= mul_z; resp_valid[id] <= 1; pend[id] <= 0.
- Latency: grant cycle t gives resp_valid high from cycle t+2+MUL_LAT, which is 6 at the defaults.
- Response hold: resp_valid[i] and resp_data[i] stay stable until resp_valid[i] & resp_ready[i]; resp_valid[i] clears at the end of that cycle.
- Reissue: requester i is not eligible in the resp handshake cycle. The earliest regrant is the next cycle.
- Simultaneous events:
  - A return to i and a grant to j≠i in the same cycle are independent.
  - A return to i cannot coincide with busy[i] clearing, so result slots never overflow.
- in_flight: +1 on grant, -1 on return, unchanged when both happen. Range 0..min(N_REQ, MUL_LAT+1).
- Reset values:
  - req_ready combinationally 0 while rst is high.
  - resp_valid=0, resp_data=0, mul_a=0, mul_b=0, in_flight=0.
  - All tag vld=0, pend=0, ptr=0.
- Reset mid-operation: all in-flight tags and responses are dropped. FPmul is not reset; its stale products are ignored because no tag is valid.
- Zero, Inf and NaN operands pass through unmodified. The scheduler does no arithmetic.

Decomposition:
- Package fpmul_sched_pkg holds:
  - DATA_W and the default MUL_LAT.
  - typedef id_t = logic [$clog2(N_REQ)-1:0].
  - typedef tag_t struct {vld, id}.
- Sub-module rr_arbiter (N parameter): inputs req vector and ptr; output one-hot grant and grant index.
- The FPmul instance lives in the parent, not in this block.

Test Plan:
- Single op: req0 issues 0x3FC00000 × 0x40000000 at cycle 0 -> req_ready[0]=1 at cycle 0; mul_a=0x3FC00000 at cycle 1; resp_valid[0] at cycle 6 with resp_data 0x40400000 (3.0).
- All four request at cycle 0 (operand pairs 1.5×2.0, -2.0×0.5, 2.5×4.0, 0×7.0) -> grants 0,1,2,3 in cycles 0..3. Responses in cycles 6..9: 0x40400000, 0xBF800000, 0x41200000, 0x00000000. in_flight peaks at 4.
- Backpressure: resp_ready[1]=0 for 10 cycles while req1 keeps req_valid -> resp_data[1] stable and req_ready[1]=0 throughout; req1 regranted the cycle after its handshake; other requesters keep issuing.
- Fairness: req0 and req2 held valid continuously with resp_ready=1 -> grants alternate 0,2,0,2 and neither starves. ptr advances past the granted index.
- Reset mid-flight: rst at cycle 3 of the four-request test -> all resp_valid stay 0 after reset and in_flight=0. A new req3 at post-reset cycle 0 gets its correct product at cycle 6.
- Idle/throughput: back-to-back single requester with immediate resp_ready -> issue every MUL_LAT+3 cycles (7 cycles); mul_a/mul_b do not change in no-grant cycles.
